// File: rtl/issue_scoreboard.sv
// In-order N-wide issue hazard unit: intra-bundle RAW/WAW checks plus a per-register
// latency scoreboard that holds consumers until a multi-cycle result can be forwarded.
module issue_scoreboard #(
   parameter int ISSUE_W = 2,
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int LAT_W   = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ISSUE_W-1:0]       io_id_valid,
   input  logic [ISSUE_W*AW-1:0]    io_id_rs1,
   input  logic [ISSUE_W*AW-1:0]    io_id_rs2,
   input  logic [ISSUE_W*AW-1:0]    io_id_rd,
   input  logic [ISSUE_W-1:0]       io_id_rdwen,
   input  logic [ISSUE_W*LAT_W-1:0] io_id_lat,
   input  logic                     io_ex_ready,
   input  logic                     io_flush,
   input  logic                     io_wb_clr_en,
   input  logic [AW-1:0]            io_wb_clr_rd,
   output logic [ISSUE_W-1:0]       io_issue,
   output logic                     io_stallex,
   output logic [NREG-1:0]          io_busy
);

   localparam logic [LAT_W-1:0] LAT_MAX = '1;

   logic [NREG-1:0]    busy;
   logic [ISSUE_W-1:0] issue;

   // chain_ok carries "every older slot issued", so the issue mask is always a prefix
   always_comb begin : issue_logic
      logic          chain_ok;
      logic          slot_ok;
      logic [AW-1:0] rs1_i;
      logic [AW-1:0] rs2_i;
      logic [AW-1:0] rd_i;
      logic [AW-1:0] rd_j;
      issue    = '0;
      slot_ok  = 1'b0;
      rs1_i    = '0;
      rs2_i    = '0;
      rd_i     = '0;
      rd_j     = '0;
      chain_ok = ~reset & io_ex_ready & ~io_flush;
      for (int i = 0; i < ISSUE_W; i++) begin
         rs1_i   = io_id_rs1[i*AW +: AW];
         rs2_i   = io_id_rs2[i*AW +: AW];
         rd_i    = io_id_rd[i*AW +: AW];
         slot_ok = chain_ok & io_id_valid[i] & ~busy[rs1_i] & ~busy[rs2_i];
         if (io_id_rdwen[i] && rd_i != '0 && busy[rd_i])
            slot_ok = 1'b0;
         for (int j = 0; j < i; j++) begin
            rd_j = io_id_rd[j*AW +: AW];
            if (io_id_rdwen[j] && rd_j != '0 &&
                (rd_j == rs1_i || rd_j == rs2_i || rd_j == rd_i))
               slot_ok = 1'b0;
         end
         issue[i] = slot_ok;
         chain_ok = slot_ok;
      end
   end

   assign busy[0] = 1'b0;

   for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic [LAT_W-1:0] cnt_q;
      logic [LAT_W-1:0] cnt_d;

      // Later assignments win: new issue beats writeback clear beats countdown
      always_comb begin
         cnt_d = cnt_q;
         if (cnt_q != '0 && cnt_q != LAT_MAX)
            cnt_d = cnt_q - LAT_W'(1);
         if (io_wb_clr_en && io_wb_clr_rd == IDX && cnt_q == LAT_MAX)
            cnt_d = '0;
         for (int i = 0; i < ISSUE_W; i++) begin
            if (issue[i] && io_id_rdwen[i] && io_id_rd[i*AW +: AW] == IDX &&
                io_id_lat[i*LAT_W +: LAT_W] != '0)
               cnt_d = io_id_lat[i*LAT_W +: LAT_W];
         end
      end

      always_ff @(posedge clock) begin
         if (reset || io_flush)
            cnt_q <= '0;
         else
            cnt_q <= cnt_d;
      end

      assign busy[gi] = (cnt_q != '0);
   end

   assign io_issue   = issue;
   assign io_stallex = |(io_id_valid & ~issue);
   assign io_busy    = reset ? '0 : busy;

endmodule
